multi_deser: RTL and testbench

//  Downstream stage of the bit-serial multiplier. Collects the serial product

---
 rtl/multi_deser.sv | 156 +++++++++++++++
 tb/tb_multi_deser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_deser.sv
// multi_deser: collects an LSB-first serial product stream into W-bit words,
// queues them in a small FIFO and presents the head on a valid/ready port.
// Handshake: a word moves on every rising edge where P_VALID and P_READY are
// both 1; P_VALID never depends combinationally on P_READY, and P is stable
// while P_VALID=1 and P_READY=0.
module multi_deser #(
  parameter int W     = 8,
  parameter int LAT   = 6,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         SIN,
  input  logic         SYNC,
  output logic [W-1:0] P,
  output logic         P_VALID,
  input  logic         P_READY,
  output logic         OVF,
  output logic [7:0]   FRM_CNT
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(W);
  localparam int SKW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic {
    ST_SKIP  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // With no latency to skip, the stream is sampled from the first edge.
  localparam state_e ST_RESET = (LAT == 0) ? ST_SHIFT : ST_SKIP;

  state_e          state_q, state_d;
  logic [SKW-1:0]  skip_q, skip_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sh_q, sh_d;
  logic            done;
  logic [W-1:0]    word;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]     count_q, count_d;
  logic [W-1:0]    p_q, p_d;
  logic            pv_q, pv_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      frm_q, frm_d;
  logic            pop, push, full, drop;

  // Deserializer FSM: skip latency, then shift bits; SYNC realigns to bit 0.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
    word    = {SIN, sh_q[W-2:0]};
    if (SYNC) begin
      state_d = ST_SHIFT;
      skip_d  = '0;
      cnt_d   = CW'(1);
      sh_d    = '0;
      sh_d[0] = SIN;
    end else begin
      case (state_q)
        ST_SKIP: begin
          if (skip_q <= SKW'(1)) begin
            state_d = ST_SHIFT;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - SKW'(1);
          end
        end
        default: begin
          sh_d[cnt_q] = SIN;
          if (cnt_q == CW'(W - 1)) begin
            done  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // FIFO control: a pop on the same edge frees room for a completing word;
  // the registered head is computed from the post-edge FIFO contents.
  always_comb begin
    pop     = pv_q & P_READY;
    full    = (count_q == (AW+1)'(DEPTH));
    push    = done & (~full | pop);
    drop    = done & full & ~pop;
    rd_d    = pop  ? rd_q + AW'(1) : rd_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
    p_d = p_q;
    if (count_d != '0) begin
      if (push && (wr_q == rd_d)) begin
        p_d = word;
      end else begin
        p_d = mem_q[rd_d];
      end
    end
    pv_d  = (count_d != '0);
    ovf_d = ovf_q | drop;
    frm_d = push ? frm_q + 8'd1 : frm_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RESET;
      skip_q  <= SKW'(LAT);
      cnt_q   <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      p_q     <= '0;
      pv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      ovf_q   <= ovf_d;
      frm_q   <= frm_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_q] <= word;
    end
  end

  assign P       = p_q;
  assign P_VALID = pv_q;
  assign OVF     = ovf_q;
  assign FRM_CNT = frm_q;

endmodule

// File: tb/tb_multi_deser.sv
// Bench for multi_deser: two instances (LAT=0 and LAT=6) share stimulus and
// are compared every cycle against a frame-level reference model.
module tb_multi_deser;

  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic       CLK, RST, SIN, SYNC, P_READY;
  logic [7:0] p0, p1, frm0, frm1;
  logic       pv0, pv1, ovf0, ovf1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, one slot per instance.
  int         m_skip [2];
  int         m_pos  [2];
  logic [7:0] m_acc  [2];
  logic [7:0] m_fifo [2][DEPTH];
  int         m_cnt  [2];
  bit         m_ovf  [2];
  int         m_frm  [2];
  logic [7:0] m_last [2];

  multi_deser #(.W(W), .LAT(0), .DEPTH(DEPTH)) dut0 (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SYNC(SYNC), .P(p0), .P_VALID(pv0),
    .P_READY(P_READY), .OVF(ovf0), .FRM_CNT(frm0)
  );

  multi_deser #(.W(W), .LAT(6), .DEPTH(DEPTH)) dut1 (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SYNC(SYNC), .P(p1), .P_VALID(pv1),
    .P_READY(P_READY), .OVF(ovf1), .FRM_CNT(frm1)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_skip[k] = (k == 0) ? 0 : 6;
      m_pos[k]  = 0;
      m_acc[k]  = 8'h00;
      m_cnt[k]  = 0;
      m_ovf[k]  = 1'b0;
      m_frm[k]  = 0;
      m_last[k] = 8'h00;
    end
  endtask

  task automatic model_step(input int k, input bit sin, input bit sync, input bit rdy);
    bit         done;
    logic [7:0] w;
    done = 1'b0;
    w    = 8'h00;
    if (sync) begin
      m_acc[k]  = {7'd0, sin};
      m_pos[k]  = 1;
      m_skip[k] = 0;
    end else if (m_skip[k] > 0) begin
      m_skip[k]--;
    end else begin
      m_acc[k] = m_acc[k] | ({7'd0, sin} << m_pos[k]);
      if (m_pos[k] == W - 1) begin
        done     = 1'b1;
        w        = m_acc[k];
        m_acc[k] = 8'h00;
        m_pos[k] = 0;
      end else begin
        m_pos[k]++;
      end
    end
    if (rdy && m_cnt[k] > 0) begin
      for (int i = 0; i < DEPTH - 1; i++) m_fifo[k][i] = m_fifo[k][i+1];
      m_cnt[k]--;
    end
    if (done) begin
      if (m_cnt[k] < DEPTH) begin
        m_fifo[k][m_cnt[k]] = w;
        m_cnt[k]++;
        m_frm[k] = (m_frm[k] + 1) % 256;
      end else begin
        m_ovf[k] = 1'b1;
      end
    end
    if (m_cnt[k] > 0) m_last[k] = m_fifo[k][0];
  endtask

  task automatic compare_all();
    chk("pv0",  {31'd0, pv0},  {31'd0, m_cnt[0] > 0});
    chk("p0",   {24'd0, p0},   {24'd0, m_last[0]});
    chk("ovf0", {31'd0, ovf0}, {31'd0, m_ovf[0]});
    chk("frm0", {24'd0, frm0}, 32'(m_frm[0]));
    chk("pv1",  {31'd0, pv1},  {31'd0, m_cnt[1] > 0});
    chk("p1",   {24'd0, p1},   {24'd0, m_last[1]});
    chk("ovf1", {31'd0, ovf1}, {31'd0, m_ovf[1]});
    chk("frm1", {24'd0, frm1}, 32'(m_frm[1]));
  endtask

  // One clock of stimulus: drive, take the edge, advance the model, check.
  task automatic step(input bit sin, input bit sync, input bit rdy);
    SIN     = sin;
    SYNC    = sync;
    P_READY = rdy;
    @(posedge CLK);
    model_step(0, sin, sync, rdy);
    model_step(1, sin, sync, rdy);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] w, input bit sync0, input bit rdy_all,
                            input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      step(w[i], sync0 && (i == 0), (i == W - 1) ? rdy_last : rdy_all);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs checked before any edge.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    RST = 1'b1; SIN = 1'b0; SYNC = 1'b0; P_READY = 1'b0;
    model_reset();
    #12;
    compare_all();
    RST = 1'b0;

    // 1: single framed word, consumer ready
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    chk("t1_p", {24'd0, p0}, 32'h5A);
    chk("t1_pv", {31'd0, pv0}, 32'd1);
    chk("t1_frm", {24'd0, frm0}, 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t1_pv_drop", {31'd0, pv0}, 32'd0);

    // 2: three frames into a stalled consumer, third dropped
    do_reset();
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0, 1'b0);
    chk("t2_p", {24'd0, p0}, 32'h01);
    chk("t2_ovf", {31'd0, ovf0}, 32'd1);
    chk("t2_frm", {24'd0, frm0}, 32'd2);
    step(1'b1, 1'b0, 1'b1);
    chk("t2_pop1", {24'd0, p0}, 32'h02);
    step(1'b0, 1'b0, 1'b1);
    chk("t2_empty", {31'd0, pv0}, 32'd0);
    chk("t2_ovf_sticky", {31'd0, ovf0}, 32'd1);

    // 3: full FIFO, pop coincides with completion -> accepted
    do_reset();
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf", {31'd0, ovf0}, 32'd0);
    chk("t3_head", {24'd0, p0}, 32'h02);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_pop2", {24'd0, p0}, 32'hC3);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_empty", {31'd0, pv0}, 32'd0);

    // 4: SYNC mid-frame discards the partial word
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    chk("t4_p", {24'd0, p0}, 32'h81);
    chk("t4_frm", {24'd0, frm0}, 32'd1);
    chk("t4_ovf", {31'd0, ovf0}, 32'd0);

    // 5: latency skip on the LAT=6 instance, then reset mid-frame
    do_reset();
    for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t5_p", {24'd0, p1}, 32'h3C);
    chk("t5_pv", {31'd0, pv1}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    do_reset();
    chk("t5_rst_pv", {31'd0, pv1}, 32'd0);
    chk("t5_rst_frm", {24'd0, frm1}, 32'd0);

    // 6: 256 frames wrap the frame counter
    for (int f = 0; f < 256; f++) begin
      w = 8'($urandom_range(0, 255));
      send_frame(w, f == 0, 1'b1, 1'b1);
    end
    chk("t6_frm", {24'd0, frm0}, 32'd0);
    chk("t6_ovf", {31'd0, ovf0}, 32'd0);
    chk("t6_p", {24'd0, p0}, {24'd0, w});

    // Random stream with occasional SYNC, varying backpressure and resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      step(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
           ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
